// File: rtl/neuron_mac_seq.sv
// Sequential signed fixed-point neuron: one saturating MAC per cycle over N_INPUTS, then activation.
// Optional feature: define NEURON_RELU_EN for a ReLU output stage; otherwise the output is linear.
module neuron_mac_seq #(
  parameter int N_INPUTS = 4,
  parameter int IN_W     = 12,
  parameter int ACC_W    = 24,
  parameter int FRAC     = 8,
  localparam int AW      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_INPUTS*IN_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic [IN_W-1:0]          w_data,
  input  logic                     b_we,
  input  logic [ACC_W-1:0]         b_data,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  // state | meaning
  // IDLE  | waiting for an input vector; weight/bias writes accepted
  // MAC   | one product accumulated per cycle, idx 0..N_INPUTS-1
  // ACT   | activation applied, result registered
  // OUT   | result held until the downstream handshake
  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

  localparam int PW = 2 * IN_W;
  localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [IN_W-1:0]  in_q  [N_INPUTS];
  logic signed [IN_W-1:0]  w_q   [N_INPUTS];
  logic signed [IN_W-1:0]  w_use [N_INPUTS];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] bias_q;
  logic        [ACC_W-1:0] out_q;
  logic        [AW-1:0]    idx_q;

  logic                    accept;
  logic                    last_idx;
  logic                    w_wr_ok;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    prod_sh;
  logic signed [SW-1:0]    prod_x;
  logic signed [SW-1:0]    acc_x;
  logic signed [SW-1:0]    sum;
  logic signed [ACC_W-1:0] acc_next;
  logic        [ACC_W-1:0] act_val;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = MAC;
      end
      MAC:  if (last_idx) state_d = ACT;
      ACT:  state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_idx = (idx_q == AW'(N_INPUTS - 1));
  assign w_wr_ok  = w_we && (state_q == IDLE) && (32'(w_addr) < N_INPUTS);

  // Full-precision product, floor-shifted, then summed in a width that cannot overflow before clamping
  always_comb begin
    prod    = in_q[idx_q] * w_use[idx_q];
    prod_sh = prod >>> FRAC;
    prod_x  = {{(SW-PW){prod_sh[PW-1]}}, prod_sh};
    acc_x   = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    sum     = prod_x + acc_x;
    if (sum > SAT_MAX)      acc_next = SAT_MAX[ACC_W-1:0];
    else if (sum < SAT_MIN) acc_next = SAT_MIN[ACC_W-1:0];
    else                    acc_next = sum[ACC_W-1:0];
  end

  always_comb begin
`ifdef NEURON_RELU_EN
    act_val = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    act_val = acc_q;
`endif
  end

  // Weights are snapshotted on accept so a write in the same cycle only affects later vectors
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      bias_q <= '0;
      out_q  <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        in_q[i]  <= '0;
        w_q[i]   <= '0;
        w_use[i] <= '0;
      end
    end else begin
      if (w_wr_ok) w_q[w_addr] <= w_data;
      if (b_we && (state_q == IDLE)) bias_q <= b_data;
      if (accept) begin
        acc_q <= bias_q;
        idx_q <= '0;
        for (int i = 0; i < N_INPUTS; i++) begin
          in_q[i]  <= in_data[i*IN_W +: IN_W];
          w_use[i] <= w_q[i];
        end
      end
      if (state_q == MAC) begin
        acc_q <= acc_next;
        idx_q <= idx_q + AW'(1);
      end
      if (state_q == ACT) out_q <= act_val;
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: a reference model pushes expected results at accept,
// and they are popped and compared at the output handshake.
`timescale 1ns/1ps
module tb_neuron_mac_seq;
  localparam int N  = 4;
  localparam int IW = 12;
  localparam int OW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N*IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          w_we = 1'b0;
  logic [1:0]    w_addr = '0;
  logic [IW-1:0] w_data = '0;
  logic          b_we = 1'b0;
  logic [OW-1:0] b_data = '0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  neuron_mac_seq dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we), .b_data(b_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_q[$];
  logic [IW-1:0] m_w [N];
  logic [OW-1:0] m_bias;
  logic [OW-1:0] last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [N*IW-1:0] vec);
    longint acc, p;
    logic signed [IW-1:0] a, b;
    logic signed [OW-1:0] bb;
    bb  = m_bias;
    acc = longint'(bb);
    for (int i = 0; i < N; i++) begin
      a = vec[i*IW +: IW];
      b = m_w[i];
      p = (longint'(a) * longint'(b)) >>> 8;
      acc = acc + p;
      if (acc > 64'sd8388607)  acc = 64'sd8388607;
      if (acc < -64'sd8388608) acc = -64'sd8388608;
    end
`ifdef NEURON_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc[OW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; w_we = 1'b0; b_we = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < N; i++) m_w[i] = '0;
    m_bias = '0;
    exp_q.delete();
  endtask

  task automatic write_w(input int a, input logic [IW-1:0] v);
    w_addr = a[1:0]; w_data = v; w_we = 1'b1;
    step();
    w_we = 1'b0;
    m_w[a] = v;
  endtask

  task automatic write_all_w(input logic [IW-1:0] v);
    for (int i = 0; i < N; i++) write_w(i, v);
  endtask

  task automatic write_b(input logic [OW-1:0] v);
    b_data = v; b_we = 1'b1;
    step();
    b_we = 1'b0;
    m_bias = v;
  endtask

  function automatic logic [N*IW-1:0] splat(input logic [IW-1:0] v);
    logic [N*IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = v;
    return r;
  endfunction

  task automatic send(input logic [N*IW-1:0] vec);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_data = vec; in_valid = 1'b1;
    exp_q.push_back(model(vec));
    step();
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
  endtask

  task automatic recv(input string tag);
    logic [OW-1:0] e;
    out_ready = 1'b1;
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    check(tag, {8'd0, out_data}, {8'd0, e});
    check("out_valid_high", {31'd0, out_valid}, 32'd1);
    last_out = out_data;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input logic [N*IW-1:0] vec, input string tag);
    int n;
    send(vec);
    wait_out(n);
    check("latency", n, N + 1);
    recv(tag);
  endtask

  initial begin
    int n;
    logic [N*IW-1:0] v;
    logic [OW-1:0] hold;

    do_reset();
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    write_all_w(12'h080);
    write_b(24'h000040);
    run(splat(12'h100), "half_weights");
    check("half_weights_const", {8'd0, last_out}, 32'h000240);

    write_all_w(12'hF00);
    write_b(24'h000000);
    run(splat(12'h100), "neg_weights");
`ifdef NEURON_RELU_EN
    check("neg_weights_const", {8'd0, last_out}, 32'h000000);
`else
    check("neg_weights_const", {8'd0, last_out}, 32'hFFFC00);
`endif

    write_all_w(12'h100);
    write_b(24'h7FFFFF);
    run(splat(12'h100), "sat_pos");
    check("sat_pos_const", {8'd0, last_out}, 32'h7FFFFF);
    write_all_w(12'hF00);
    write_b(24'h800000);
    run(splat(12'h100), "sat_neg");
`ifndef NEURON_RELU_EN
    check("sat_neg_const", {8'd0, last_out}, 32'h800000);
`endif

    // Backpressure: result must hold while in_valid pulses are ignored
    write_all_w(12'h0C0);
    write_b(24'h000010);
    v = {12'h050, 12'hFA0, 12'h200, 12'h123};
    send(v);
    wait_out(n);
    check("bp_latency", n, N + 1);
    hold = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = splat(12'h7FF);
      step();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {8'd0, out_data}, {8'd0, hold});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    recv("bp_result");
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_second_result", {31'd0, out_valid}, 32'd0);
    end

    // Weight write during MAC must be dropped
    write_all_w(12'h100);
    write_b(24'h000000);
    v = {12'h010, 12'h020, 12'h030, 12'h040};
    send(v);
    w_addr = 2'd0; w_data = 12'h7FF; w_we = 1'b1;
    step();
    w_we = 1'b0;
    wait_out(n);
    check("mac_write_latency", n + 1, N + 1);
    recv("mac_write_ignored");
    write_w(0, 12'h7FF);
    run(v, "idle_write_applied");

    // Write in the same cycle as an accept: old weight for this vector, new one afterwards
    v = {12'h100, 12'h100, 12'h100, 12'h100};
    w_addr = 2'd1; w_data = 12'h040; w_we = 1'b1;
    send(v);
    w_we = 1'b0;
    m_w[1] = 12'h040;
    wait_out(n);
    check("acc_write_latency", n, N + 1);
    recv("accept_write_old");
    run(v, "accept_write_new");

    // Reset mid-MAC
    write_b(24'h000123);
    send(splat(12'h155));
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) m_w[i] = '0;
    m_bias = '0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {8'd0, out_data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run(splat(12'h3A5), "post_rst");
    check("post_rst_const", {8'd0, last_out}, 32'd0);

    // Random vectors
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) write_w(i, 12'($urandom));
      write_b(24'($urandom_range(0, 32'h00FFFF)) ^ (t[0] ? 24'hFF0000 : 24'h0));
      run(48'({$urandom, $urandom}), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Parametrised sequential neuron: signed fixed-point multiply-accumulate of N_INPUTS inputs against runtime-loadable weights plus bias, then optional ReLU. It adds valid/ready handshakes on input and output, a weight/bias write port and saturating accumulation. It is the per-neuron building block for the layer arrays of the hardware network, one instance per neuron, fed by the layer controller.

## Interface
- N_INPUTS, 4: inputs/weights per neuron (≥1)
- IN_W, 12: input and weight width, signed two's complement
- ACC_W, 24: accumulator, bias and output width, signed (ACC_W ≥ IN_W+1)
- FRAC, 8: fractional bits of inputs, weights, bias and output
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- in_data  in  N_INPUTS*IN_W  packed inputs, input i at [i*IN_W +: IN_W]
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- w_we  in  1  weight write strobe
- w_addr  in  $clog2(N_INPUTS) (min 1)  weight index
- w_data  in  IN_W  weight value
- b_we  in  1  bias write strobe
- b_data  in  ACC_W  bias value
- out_data  out  ACC_W  result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, MAC, ACT, OUT.
- IDLE: in_ready=1. When in_valid=1 at an edge, latch all inputs, acc←bias, idx←0, go to MAC.
- MAC: each cycle acc←sat(acc + ext(prod[idx])), idx←idx+1. After idx=N_INPUTS-1 is processed, go to ACT.
- prod = signed in[idx] × w[idx] (2·IN_W bits), arithmetic right shift by FRAC (truncation toward −∞), sign-extended to ACC_W.
- sat(): clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1] after every add. No wrap-around at any point.
- ACT: out_data←act(acc), out_valid←1, go to OUT.
- OUT: hold out_data and out_valid. On out_valid&out_ready at an edge: out_valid←0, go to IDLE.
- Weight/bias writes are applied only in IDLE, including in the same cycle as an input accept; the accepted vector uses the old values. Writes outside IDLE, and w_addr ≥ N_INPUTS, are dropped silently.
- Reset (rst=0 at an edge), in any state including mid-MAC: state←IDLE, acc←0, idx←0, all weights←0, bias←0. The in-flight vector is discarded.

## Timing
- Reset values: out_data=0, out_valid=0, in_ready=1 (after the first post-reset cycle; combinational from state IDLE), busy=0.
- If the input is accepted at edge k, MAC updates occur at edges k+1…k+N_INPUTS, and out_valid rises at edge k+N_INPUTS+1.
- Latency from accept to out_valid = N_INPUTS+1 cycles (5 at default).
- in_ready returns 1 in the cycle after the output handshake. Minimum period is N_INPUTS+3 cycles per vector.
- in_ready and busy are decoded from state only. They do not depend combinationally on in_valid or out_ready.
- While in OUT with out_ready=0, out_data is stable and in_valid is ignored.

## Configuration
- NEURON_RELU_EN defined: act(x) = x<0 ? 0 : x.
- NEURON_RELU_EN undefined: act(x) = x (linear output, still saturated).

## Test plan
- Default params. Weights all 0x080 (0.5), bias 0x000040 (0.25), inputs all 0x100 (1.0) → out_data=0x000240 (2.25); out_valid rises 5 cycles after accept.
- Weights all 0xF00 (−1.0), bias 0, inputs 0x100 → with NEURON_RELU_EN, out_data=0x000000; without it, out_data=0xFFFC00 (−4.0).
- Bias 0x7FFFFF, weights 0x100, inputs 0x100 → out_data=0x7FFFFF, saturated with no wrap. Then bias 0x800000, weights 0xF00 → 0x800000 without the macro.
- Hold out_ready=0 for 10 cycles while pulsing in_valid → out_data and out_valid are stable, in_ready=0, and no second result appears. Raise out_ready → one handshake, then in_ready=1 on the next cycle.
- Write w_addr=0 with 0x7FF during MAC → ignored, so the result matches the pre-write weights. The same write in IDLE takes effect on the next vector.
- Assert rst=0 for one edge mid-MAC → out_valid=0, out_data=0, busy=0, and weights read back as zero (next vector with bias 0 → out_data=0).
